// File: rtl/wash_pkg.sv
// Shared definitions for the wash cycle controller.
//   state_t      : FSM state type, encoding visible on the phase output
//   FREQ_*       : clk_freq select codes (prescale multiplier 1x/2x/4x/8x)
//   scale_prescale(): cycles per second for a base rate and a frequency code
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] FREQ_1X = 2'b00;
  localparam logic [1:0] FREQ_2X = 2'b01;
  localparam logic [1:0] FREQ_4X = 2'b10;
  localparam logic [1:0] FREQ_8X = 2'b11;

  // The frequency code is the shift amount: each step doubles the clock rate.
  function automatic logic [31:0] scale_prescale(input logic [31:0] base,
                                                 input logic [1:0]  freq);
    return base << freq;
  endfunction

endpackage

// File: rtl/wash_cycle_controller_if.sv
// Control/status bundle between the machine front panel and the controller.
//   master : front panel side, drives the requests and the clock-rate select
//   slave  : controller side, drives phase and the actuator/status outputs
// soft_rst is active-low; all other requests are active-high.
interface wash_cycle_controller_if;
  import wash_pkg::*;

  logic       soft_rst;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic [1:0] clk_freq;

  logic [2:0] phase;
  logic       valve_open;
  logic       motor_on;
  logic       busy;
  logic       wash_done;

  modport master (
    output soft_rst, coin_in, double_wash, timer_pause, clk_freq,
    input  phase, valve_open, motor_on, busy, wash_done
  );

  modport slave (
    input  soft_rst, coin_in, double_wash, timer_pause, clk_freq,
    output phase, valve_open, motor_on, busy, wash_done
  );

endinterface

// File: rtl/wash_cycle_controller_phase_timer.sv
// phase_timer: prescaler (0..c_value-1) feeding a seconds counter
// (0..sec_limit-1).
//   clear     : synchronous clear of both counters (wins over enable)
//   enable    : advance the prescaler this cycle; low freezes both counters
//   c_value   : clk cycles per second
//   sec_limit : seconds in the current phase
//   expire    : high in the last enabled cycle of the phase
module phase_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] c_value,
  input  logic [31:0] sec_limit,
  output logic        expire
);

  logic [31:0] presc_q;
  logic [31:0] sec_q;
  logic        presc_last;
  logic        sec_last;

  assign presc_last = (presc_q == c_value - 32'd1);
  assign sec_last   = (sec_q == sec_limit - 32'd1);
  assign expire     = enable && presc_last && sec_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else if (clear) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else if (enable) begin
      if (presc_last) begin
        presc_q <= '0;
        sec_q   <= sec_last ? 32'd0 : sec_q + 32'd1;
      end else begin
        presc_q <= presc_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: IDLE -> FILL -> WASH -> RINSE [-> WASH -> RINSE]
// -> SPIN -> DONE -> IDLE, each timed phase lasting PHASE_SEC seconds of
// (PRESCALE_BASE << clk_freq) clock cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of wash_cycle_controller_if
//                inputs  soft_rst (sync, active-low abort), coin_in,
//                        double_wash, timer_pause (SPIN only), clk_freq
//                outputs phase, valve_open, motor_on, busy, wash_done
// clk_freq and double_wash are captured when the coin starts a cycle and
// are ignored for the rest of it.
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter int unsigned PRESCALE_BASE = 1_000_000,
  parameter int unsigned FILL_SEC      = 120,
  parameter int unsigned WASH_SEC      = 300,
  parameter int unsigned RINSE_SEC     = 120,
  parameter int unsigned SPIN_SEC      = 60
) (
  input logic                       clk,
  input logic                       rst_n,
  wash_cycle_controller_if.slave    bus
);

  state_t      state_q;
  state_t      state_next;
  logic        second_pass_q;
  logic [1:0]  freq_q;
  logic        double_q;

  logic        paused;
  logic        timer_en;
  logic        timer_clear;
  logic        expire;
  logic [31:0] c_value;
  logic [31:0] sec_limit;

  // Pause only bites in SPIN; elsewhere it is a no-op.
  assign paused  = (state_q == ST_SPIN) && bus.timer_pause;
  assign c_value = scale_prescale(32'(PRESCALE_BASE), freq_q);

  always_comb begin
    sec_limit = 32'd1;
    timer_en  = 1'b0;
    unique case (state_q)
      ST_FILL:  begin sec_limit = 32'(FILL_SEC);  timer_en = 1'b1;    end
      ST_WASH:  begin sec_limit = 32'(WASH_SEC);  timer_en = 1'b1;    end
      ST_RINSE: begin sec_limit = 32'(RINSE_SEC); timer_en = 1'b1;    end
      ST_SPIN:  begin sec_limit = 32'(SPIN_SEC);  timer_en = !paused; end
      default:  ;
    endcase
  end

  // Any state change (including a soft abort) restarts the timer from zero.
  assign timer_clear = (state_next != state_q) || !bus.soft_rst;

  phase_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .enable    (timer_en),
    .c_value   (c_value),
    .sec_limit (sec_limit),
    .expire    (expire)
  );

  // NOTE: next-state takes its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state_q;
    if (!bus.soft_rst) begin
      state_next = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.coin_in) state_next = ST_FILL;
        ST_FILL:  if (expire)      state_next = ST_WASH;
        ST_WASH:  if (expire)      state_next = ST_RINSE;
        ST_RINSE: if (expire)      state_next = (double_q && !second_pass_q) ? ST_WASH
                                                                             : ST_SPIN;
        // expire is already masked by pause through the timer enable.
        ST_SPIN:  if (expire)      state_next = ST_DONE;
        ST_DONE:                   state_next = ST_IDLE;
        default:                   state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: only control registers exist here, so every one of them is put in
  // a known state by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      second_pass_q <= 1'b0;
      freq_q        <= FREQ_1X;
      double_q      <= 1'b0;
    end else begin
      state_q <= state_next;
      if (!bus.soft_rst || state_q == ST_IDLE) begin
        second_pass_q <= 1'b0;
      end else if (state_q == ST_RINSE && state_next == ST_WASH) begin
        second_pass_q <= 1'b1;
      end
      if (state_q == ST_IDLE && state_next == ST_FILL) begin
        freq_q   <= bus.clk_freq;
        double_q <= bus.double_wash;
      end
    end
  end

  // Outputs decode the registered state; only motor_on sees the live pause.
  assign bus.phase      = state_q;
  assign bus.valve_open = (state_q == ST_FILL);
  assign bus.motor_on   = (state_q == ST_WASH) || (state_q == ST_RINSE) ||
                          ((state_q == ST_SPIN) && !bus.timer_pause);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.wash_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Scoreboard bench: stimulus pushes the expected sequence of non-IDLE phase
// segments (phase, length in cycles); a monitor sampling on the falling edge
// pops and compares each segment as it completes, and checks the output
// decode of every sampled cycle.
module tb_wash_cycle_controller;

  typedef struct {
    logic [2:0] ph;
    int         len;
  } seg_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  seg_t exp_q[$];

  wash_cycle_controller_if bus ();

  wash_cycle_controller #(
    .PRESCALE_BASE (4),
    .FILL_SEC      (2),
    .WASH_SEC      (3),
    .RINSE_SEC     (2),
    .SPIN_SEC      (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seg(input logic [2:0] ph, input int len);
    seg_t s;
    s.ph  = ph;
    s.len = len;
    exp_q.push_back(s);
  endtask

  // One normal single-pass cycle at clk_freq=00: C=4.
  task automatic push_case1();
    push_seg(3'd1, 8);
    push_seg(3'd2, 12);
    push_seg(3'd3, 8);
    push_seg(3'd4, 4);
    push_seg(3'd5, 1);
  endtask

  // Monitor: per-cycle output decode plus segment scoreboard.
  initial begin
    logic [2:0] prev_ph;
    int         run_len;
    logic       motor_exp;
    prev_ph = 3'd0;
    run_len = 0;
    forever begin
      @(negedge clk);
      motor_exp = (bus.phase == 3'd2) || (bus.phase == 3'd3) ||
                  ((bus.phase == 3'd4) && !bus.timer_pause);
      check("valve_open", 32'(bus.valve_open), 32'(bus.phase == 3'd1));
      check("busy",       32'(bus.busy),       32'(bus.phase != 3'd0));
      check("wash_done",  32'(bus.wash_done),  32'(bus.phase == 3'd5));
      check("motor_on",   32'(bus.motor_on),   32'(motor_exp));
      if (bus.phase == prev_ph) begin
        run_len++;
      end else begin
        if (prev_ph != 3'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_segment_phase", 32'(prev_ph), 32'd0);
          end else begin
            seg_t e;
            e = exp_q.pop_front();
            check("segment_phase", 32'(prev_ph), 32'(e.ph));
            check("segment_len",   32'(run_len), 32'(e.len));
          end
        end
        prev_ph = bus.phase;
        run_len = 1;
      end
    end
  end

  task automatic wait_phase(input logic [2:0] ph, input string name);
    int n;
    n = 0;
    while (bus.phase != ph && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (bus.phase != ph) check(name, 32'(bus.phase), 32'(ph));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic coin_pulse(input logic [1:0] freq, input logic dw);
    @(posedge clk); #1;
    bus.coin_in     = 1'b1;
    bus.clk_freq    = freq;
    bus.double_wash = dw;
    @(posedge clk); #1;
    bus.coin_in     = 1'b0;
    bus.double_wash = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.soft_rst    = 1'b1;
    bus.coin_in     = 1'b0;
    bus.double_wash = 1'b0;
    bus.timer_pause = 1'b0;
    bus.clk_freq    = 2'b00;
    #1;
    check("reset_phase", 32'(bus.phase),      32'd0);
    check("reset_valve", 32'(bus.valve_open), 32'd0);
    check("reset_motor", 32'(bus.motor_on),   32'd0);
    check("reset_busy",  32'(bus.busy),       32'd0);
    check("reset_done",  32'(bus.wash_done),  32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Case 1: plain cycle.
    push_case1();
    coin_pulse(2'b00, 1'b0);
    drain("case1_drain");

    // Case 2: 2x clock, double wash: C=8.
    push_seg(3'd1, 16);
    push_seg(3'd2, 24);
    push_seg(3'd3, 16);
    push_seg(3'd2, 24);
    push_seg(3'd3, 16);
    push_seg(3'd4, 8);
    push_seg(3'd5, 1);
    coin_pulse(2'b01, 1'b1);
    bus.clk_freq = 2'b00;
    drain("case2_drain");

    // Case 3: pause in WASH ignored, pause of 5 cycles in SPIN stretches it.
    push_seg(3'd1, 8);
    push_seg(3'd2, 12);
    push_seg(3'd3, 8);
    push_seg(3'd4, 9);
    push_seg(3'd5, 1);
    coin_pulse(2'b00, 1'b0);
    wait_phase(3'd2, "case3_reach_wash");
    @(posedge clk); #1 bus.timer_pause = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.timer_pause = 1'b0;
    wait_phase(3'd4, "case3_reach_spin");
    @(posedge clk);
    @(posedge clk); #1 bus.timer_pause = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.timer_pause = 1'b0;
    drain("case3_drain");

    // Case 4: soft abort in WASH, then a fresh full cycle.
    push_seg(3'd1, 8);
    push_seg(3'd2, 2);
    coin_pulse(2'b00, 1'b0);
    wait_phase(3'd2, "case4_reach_wash");
    @(posedge clk); #1 bus.soft_rst = 1'b0;
    @(posedge clk); #1 bus.soft_rst = 1'b1;
    #1 check("case4_busy_after_abort", 32'(bus.busy), 32'd0);
    drain("case4_abort_drain");
    push_case1();
    coin_pulse(2'b00, 1'b0);
    drain("case4_restart_drain");

    // Case 5: clk_freq and coin_in disturbed while busy.
    push_case1();
    coin_pulse(2'b00, 1'b0);
    @(posedge clk); #1 bus.clk_freq = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 bus.coin_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.coin_in = 1'b0;
    end
    drain("case5_drain");
    bus.clk_freq = 2'b00;

    // Coin held high through DONE restarts immediately after one IDLE cycle.
    push_case1();
    push_case1();
    @(posedge clk); #1 bus.coin_in = 1'b1;
    wait_phase(3'd5, "hold_reach_done");
    wait_phase(3'd1, "hold_restart_fill");
    @(posedge clk); #1 bus.coin_in = 1'b0;
    drain("hold_drain");

    // Case 6: asynchronous reset mid-RINSE.
    push_seg(3'd1, 8);
    push_seg(3'd2, 12);
    push_seg(3'd3, 1);
    coin_pulse(2'b00, 1'b0);
    wait_phase(3'd3, "case6_reach_rinse");
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("case6_phase", 32'(bus.phase),      32'd0);
    check("case6_valve", 32'(bus.valve_open), 32'd0);
    check("case6_motor", 32'(bus.motor_on),   32'd0);
    check("case6_busy",  32'(bus.busy),       32'd0);
    check("case6_done",  32'(bus.wash_done),  32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drain("case6_drain");

    // The machine must return to a clean single cycle after the reset.
    push_case1();
    coin_pulse(2'b00, 1'b0);
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_controller.md
WASH_CYCLE_CONTROLLER -- requirements
Module: wash_cycle_controller

Interface
REQ-001 Parameter PRESCALE_BASE, default 1_000_000, clk cycles per second when clk_freq=00.
REQ-002 Parameter FILL_SEC, default 120, fill phase length in seconds.
REQ-003 Parameter WASH_SEC, default 300, wash phase length in seconds.
REQ-004 Parameter RINSE_SEC, default 120, rinse phase length in seconds.
REQ-005 Parameter SPIN_SEC, default 60, spin phase length in seconds.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 soft_rst  input  1  synchronous, active-low abort to IDLE.
REQ-009 coin_in  input  1  start request, level-sampled.
REQ-010 double_wash  input  1  run wash+rinse twice, sampled at start.
REQ-011 timer_pause  input  1  freeze request, honoured only in SPIN.
REQ-012 clk_freq  input  2  clock-rate select: 00=1x, 01=2x, 10=4x, 11=8x PRESCALE_BASE.
REQ-013 phase  output  3  current state encoding (see REQ-016).
REQ-014 valve_open, motor_on, busy  output  1 each  fill valve, drum motor, cycle in progress.
REQ-015 wash_done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states with encodings: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5; encodings 6-7 unreachable; if entered, next state is IDLE.
REQ-017 IDLE->FILL when coin_in=1; clk_freq and double_wash are latched on that edge and held constant for the whole cycle.
REQ-018 C = PRESCALE_BASE << latched clk_freq, width 32 bits; each phase lasts exactly PHASE_SEC*C cycles of state residency (pause cycles excluded).
REQ-019 Sequence: FILL->WASH->RINSE; from RINSE go to WASH if latched double_wash=1 and first pass, else to SPIN; SPIN->DONE; DONE->IDLE after exactly one cycle.
REQ-020 Prescaler (0..C-1) and second counter (0..PHASE_SEC-1) clear on every state change; transition occurs on the edge where the second counter = PHASE_SEC-1 and the prescaler = C-1.
REQ-021 In SPIN with timer_pause=1: both counters hold, state holds, motor_on=0; on release, counting resumes from the held values.
REQ-022 timer_pause outside SPIN: ignored.
REQ-023 coin_in outside IDLE: ignored; coin_in held high through DONE restarts the cycle from IDLE on the following edge.
REQ-024 valve_open=1 only in FILL; motor_on=1 in WASH, RINSE, and unpaused SPIN; busy=1 in every state except IDLE.
REQ-025 wash_done=1 only in DONE (single cycle); all outputs are registered or decoded from registered state without combinational input paths, except for the pause gating of motor_on.
REQ-026 Priority, highest first: rst_n, soft_rst=0, pause, expiry; pause together with expiry in SPIN means no advance.
REQ-027 soft_rst=0 in any state: next state IDLE, counters and pass flag cleared, no wash_done pulse.

Reset
REQ-028 On rst_n=0: state IDLE, counters 0, pass flag 0, latched freq 00, latched double_wash 0; outputs phase=0, valve_open=0, motor_on=0, busy=0, wash_done=0.
REQ-029 Reset release mid-clock is synchronised externally; the block does not require a reset synchroniser.

Structure
REQ-030 State encodings and the clk_freq code constants reside in shared package wash_pkg.
REQ-031 The prescaler and second counter reside in one sub-module, phase_timer (inputs: clear, enable, c_value, sec_limit; output: expire).

Verification (PRESCALE_BASE=4, FILL_SEC=2, WASH_SEC=3, RINSE_SEC=2, SPIN_SEC=1)
REQ-032 Case 1: clk_freq=00, coin pulse -> FILL 8, WASH 12, RINSE 8, SPIN 4 cycles, then DONE with wash_done high for exactly 1 cycle, then IDLE.
REQ-033 Case 2: clk_freq=01, double_wash=1 -> FILL 16, WASH 24, RINSE 16, WASH 24, RINSE 16, SPIN 8 cycles; exactly one wash_done pulse.
REQ-034 Case 3: timer_pause held 5 cycles mid-SPIN -> SPIN lasts 4+5 cycles, motor_on=0 only during the pause; pause held during WASH has no effect.
REQ-035 Case 4: soft_rst=0 for 1 cycle in WASH -> IDLE on the next edge, busy=0, no wash_done; a fresh coin restarts at FILL with counters at 0.
REQ-036 Case 5: clk_freq changed 00->11 mid-FILL and coin_in toggled while busy -> timing is unchanged from Case 1, with no restart.
REQ-037 Case 6: rst_n asserted asynchronously in RINSE -> all outputs reach reset values before the next clk edge.
